// File: rtl/npu_dma_arb.sv
// Two-requester round-robin arbiter in front of a single-outstanding DMA engine.
// Handles zero-length requests locally and flags downstream timeouts and spurious completions.
module npu_dma_arb #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned LEN_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_src,
    input  logic [ADDR_W-1:0] req0_dst,
    input  logic [LEN_W-1:0]  req0_bytes,
    output logic              req0_ready,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_src,
    input  logic [ADDR_W-1:0] req1_dst,
    input  logic [LEN_W-1:0]  req1_bytes,
    output logic              req1_ready,
    output logic              req1_done,
    output logic              dma_req_valid,
    output logic [ADDR_W-1:0] dma_req_src,
    output logic [ADDR_W-1:0] dma_req_dst,
    output logic [LEN_W-1:0]  dma_req_bytes,
    input  logic              dma_req_ready,
    input  logic              dma_resp_done,
    output logic              busy,
    output logic              grant_id,
    input  logic              clr_err,
    output logic              err_timeout,
    output logic              err_spurious
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StZdone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  bytes_q, bytes_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [1:0]        done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_t_q, err_t_d, err_s_q, err_s_d;

    logic              winner, accept, finish, timeout, spurious;
    logic [ADDR_W-1:0] win_src, win_dst;
    logic [LEN_W-1:0]  win_bytes;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        winner    = req1_valid & (~req0_valid | ~last_q);
        accept    = (state_q == StIdle) & (req0_valid | req1_valid);
        win_src   = winner ? req1_src   : req0_src;
        win_dst   = winner ? req1_dst   : req0_dst;
        win_bytes = winner ? req1_bytes : req0_bytes;
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        bytes_d  = bytes_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        done_d   = 2'b00;
        finish   = 1'b0;
        timeout  = 1'b0;
        spurious = dma_resp_done & ((state_q == StIdle) | (state_q == StZdone) |
                                    ((state_q == StIssue) & ~dma_req_ready));
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    src_d   = win_src;
                    dst_d   = win_dst;
                    bytes_d = win_bytes;
                    grant_d = winner;
                    last_d  = winner;
                    state_d = (win_bytes == '0) ? StZdone : StIssue;
                end
            end
            StIssue: begin
                if (dma_req_ready) begin
                    if (dma_resp_done) begin
                        finish = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end
                end
            end
            StWait: begin
                if (dma_resp_done) begin
                    finish = 1'b1;
                end else if (WDOG_EN && (cnt_q == CNT_MAX)) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StZdone: finish = 1'b1;
            default: state_d = StIdle;
        endcase
        if (finish) begin
            state_d = StIdle;
            done_d  = grant_q ? 2'b10 : 2'b01;
        end
        // A new error event in the same cycle as clr_err keeps the flag set.
        err_t_d = timeout | (err_t_q & ~clr_err);
        err_s_d = spurious | (err_s_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            bytes_q <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            done_q  <= 2'b00;
            cnt_q   <= '0;
            err_t_q <= 1'b0;
            err_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            bytes_q <= bytes_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_t_q <= err_t_d;
            err_s_q <= err_s_d;
        end
    end

    assign req0_ready    = accept & ~winner;
    assign req1_ready    = accept & winner;
    assign req0_done     = done_q[0];
    assign req1_done     = done_q[1];
    assign dma_req_valid = (state_q == StIssue);
    assign dma_req_src   = src_q;
    assign dma_req_dst   = dst_q;
    assign dma_req_bytes = bytes_q;
    assign busy          = (state_q != StIdle);
    assign grant_id      = grant_q;
    assign err_timeout   = err_t_q;
    assign err_spurious  = err_s_q;

endmodule

// File: tb/tb_npu_dma_arb.sv
// Bench for npu_dma_arb: two instances (default and short watchdog) driven identically,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_npu_dma_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [63:0] req0_src = '0, req0_dst = '0, req1_src = '0, req1_dst = '0;
    logic [31:0] req0_bytes = '0, req1_bytes = '0;
    logic        dreq_ready = 1'b0, resp_done = 1'b0, clr = 1'b0;

    logic        o_r0_rdy [2], o_r1_rdy [2], o_r0_done [2], o_r1_done [2], o_dv [2];
    logic [63:0] o_src [2], o_dst [2];
    logic [31:0] o_bytes [2];
    logic        o_busy [2], o_gid [2], o_et [2], o_es [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        npu_dma_arb #(
            .ADDR_W        (64),
            .LEN_W         (32),
            .TIMEOUT_CYCLES((k == 0) ? 1024 : 8)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req0_valid   (req0_valid),
            .req0_src     (req0_src),
            .req0_dst     (req0_dst),
            .req0_bytes   (req0_bytes),
            .req0_ready   (o_r0_rdy[k]),
            .req0_done    (o_r0_done[k]),
            .req1_valid   (req1_valid),
            .req1_src     (req1_src),
            .req1_dst     (req1_dst),
            .req1_bytes   (req1_bytes),
            .req1_ready   (o_r1_rdy[k]),
            .req1_done    (o_r1_done[k]),
            .dma_req_valid(o_dv[k]),
            .dma_req_src  (o_src[k]),
            .dma_req_dst  (o_dst[k]),
            .dma_req_bytes(o_bytes[k]),
            .dma_req_ready(dreq_ready),
            .dma_resp_done(resp_done),
            .busy         (o_busy[k]),
            .grant_id     (o_gid[k]),
            .clr_err      (clr),
            .err_timeout  (o_et[k]),
            .err_spurious (o_es[k])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one open transaction, downstream-accepted flag, WAIT age.
    typedef struct {
        bit          open;
        bit          sent;
        int          cnt;
        logic [63:0] src;
        logic [63:0] dst;
        logic [31:0] bytes;
        bit          gid;
        bit          last;
        int          done_id;
        bit          et;
        bit          es;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t m_reset();
        mdl_t s;
        s.open = 0; s.sent = 0; s.cnt = 0; s.src = '0; s.dst = '0; s.bytes = '0;
        s.gid = 0; s.last = 1; s.done_id = -1; s.et = 0; s.es = 0;
        return s;
    endfunction

    function automatic mdl_t m_step(mdl_t s, int unsigned to);
        mdl_t n = s;
        bit fin = 0, tmo = 0, spur, w;
        n.done_id = -1;
        spur = resp_done && !(s.open && s.bytes != 0 && (s.sent || dreq_ready));
        if (!s.open) begin
            if (req0_valid || req1_valid) begin
                w = (req0_valid && req1_valid) ? !s.last : req1_valid;
                n.open = 1; n.sent = 0; n.cnt = 0; n.gid = w; n.last = w;
                n.src   = w ? req1_src : req0_src;
                n.dst   = w ? req1_dst : req0_dst;
                n.bytes = w ? req1_bytes : req0_bytes;
            end
        end else if (s.bytes == 0) begin
            fin = 1;
        end else if (!s.sent) begin
            if (dreq_ready) begin
                if (resp_done) fin = 1;
                else begin n.sent = 1; n.cnt = 0; end
            end
        end else begin
            if (resp_done) fin = 1;
            else if (to != 0 && s.cnt == int'(to) - 1) begin fin = 1; tmo = 1; end
            else n.cnt = s.cnt + 1;
        end
        if (fin) begin
            n.open = 0;
            n.done_id = int'(s.gid);
        end
        n.et = tmo ? 1'b1 : (clr ? 1'b0 : s.et);
        n.es = spur ? 1'b1 : (clr ? 1'b0 : s.es);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m[0] <= m_reset();
            m[1] <= m_reset();
        end else begin
            m[0] <= m_step(m[0], 1024);
            m[1] <= m_step(m[1], 8);
        end
    end

    task automatic cmp_inst(input int k);
        mdl_t  s = m[k];
        bit    w;
        string p = $sformatf("i%0d", k);
        w = (req0_valid && req1_valid) ? !s.last : req1_valid;
        chk({p, " req0_ready"}, o_r0_rdy[k], !s.open && req0_valid && !w);
        chk({p, " req1_ready"}, o_r1_rdy[k], !s.open && req1_valid && w);
        chk({p, " req0_done"}, o_r0_done[k], s.done_id == 0);
        chk({p, " req1_done"}, o_r1_done[k], s.done_id == 1);
        chk({p, " dma_req_valid"}, o_dv[k], s.open && !s.sent && s.bytes != 0);
        chk({p, " dma_req_src"}, o_src[k], s.src);
        chk({p, " dma_req_dst"}, o_dst[k], s.dst);
        chk({p, " dma_req_bytes"}, o_bytes[k], s.bytes);
        chk({p, " busy"}, o_busy[k], s.open);
        chk({p, " grant_id"}, o_gid[k], s.gid);
        chk({p, " err_timeout"}, o_et[k], s.et);
        chk({p, " err_spurious"}, o_es[k], s.es);
    endtask

    always @(negedge clk) begin
        cmp_inst(0);
        cmp_inst(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; dreq_ready = 0; resp_done = 0; clr = 0;
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    initial begin
        int n;
        bit id;

        // Reset state
        do_reset();
        #1;
        chk("rst busy", o_busy[0], 0);
        chk("rst dma_req_valid", o_dv[0], 0);
        chk("rst grant_id", o_gid[0], 0);
        chk("rst err_timeout", o_et[0], 0);
        chk("rst err_spurious", o_es[0], 0);

        // Single req0 transfer
        req0_src = 64'h30_0000_0000; req0_dst = 64'h30_0010_0000; req0_bytes = 4096;
        req0_valid = 1;
        #1 chk("t20 req0_ready", o_r0_rdy[0], 1);
        step(); req0_valid = 0;
        #1 chk("t20 dma_req_valid", o_dv[0], 1);
        chk("t20 dma_req_src", o_src[0], 64'h30_0000_0000);
        chk("t20 dma_req_dst", o_dst[0], 64'h30_0010_0000);
        chk("t20 dma_req_bytes", o_bytes[0], 4096);
        step(); dreq_ready = 1;
        #1 chk("t20 held valid", o_dv[0], 1);
        step(); dreq_ready = 0;
        #1 chk("t20 wait valid low", o_dv[0], 0);
        chk("t20 wait busy", o_busy[0], 1);
        repeat (8) step();
        step(); resp_done = 1;
        step(); resp_done = 0;
        #1 chk("t20 req0_done", o_r0_done[0], 1);
        chk("t20 busy low", o_busy[0], 0);
        step();
        #1 chk("t20 single pulse", o_r0_done[0], 0);

        // Round-robin with both requesters held valid
        do_reset();
        req0_src = 64'h1000; req0_dst = 64'h2000; req0_bytes = 256;
        req1_src = 64'h5000; req1_dst = 64'h6000; req1_bytes = 128;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n = 0;
            while (!(o_r0_rdy[0] || o_r1_rdy[0]) && n < 8) begin
                step();
                #1;
                n++;
            end
            chk("t21 handshake", o_r0_rdy[0] | o_r1_rdy[0], 1);
            id = o_r1_rdy[0];
            chk("t21 order", id, i % 2);
            step(); dreq_ready = 1;
            #1 chk("t21 src", o_src[0], (i % 2) ? 64'h5000 : 64'h1000);
            step(); dreq_ready = 0; resp_done = 1;
            step(); resp_done = 0;
            #1 chk("t21 req0_done", o_r0_done[0], (i % 2) == 0);
            chk("t21 req1_done", o_r1_done[0], (i % 2) == 1);
            if (i == 3) begin
                req0_valid = 0; req1_valid = 0;
            end
        end
        step();

        // Zero-length request from req1
        do_reset();
        req1_src = 64'h7000; req1_dst = 64'h7100; req1_bytes = 0; req1_valid = 1;
        #1 chk("t22 req1_ready", o_r1_rdy[0], 1);
        step(); req1_valid = 0;
        #1 chk("t22 no dma_req", o_dv[0], 0);
        chk("t22 busy", o_busy[0], 1);
        chk("t22 grant_id", o_gid[0], 1);
        step();
        #1 chk("t22 req1_done", o_r1_done[0], 1);
        chk("t22 req0_done", o_r0_done[0], 0);
        step();
        #1 chk("t22 pulse end", o_r1_done[0], 0);

        // Watchdog on the short-timeout instance; clear and spurious set in one cycle
        do_reset();
        req0_src = 64'h8000; req0_dst = 64'h8800; req0_bytes = 16; req0_valid = 1;
        step(); req0_valid = 0; dreq_ready = 1;
        step(); dreq_ready = 0;
        repeat (7) step();
        #1 chk("t23 busy before timeout", o_busy[1], 1);
        chk("t23 no early timeout", o_et[1], 0);
        step();
        #1 chk("t23 timeout done", o_r0_done[1], 1);
        chk("t23 err_timeout", o_et[1], 1);
        chk("t23 busy low", o_busy[1], 0);
        chk("t23 long instance busy", o_busy[0], 1);
        clr = 1; resp_done = 1;
        step(); clr = 0; resp_done = 0;
        #1 chk("t23 timeout cleared", o_et[1], 0);
        chk("t23 spurious wins clear", o_es[1], 1);
        chk("t23 long instance done", o_r0_done[0], 1);
        chk("t23 long instance no spurious", o_es[0], 0);

        // Spurious completion while idle
        do_reset();
        resp_done = 1;
        step(); resp_done = 0;
        #1 chk("t24 err_spurious", o_es[0], 1);
        chk("t24 busy", o_busy[0], 0);
        chk("t24 req0_done", o_r0_done[0], 0);
        chk("t24 req1_done", o_r1_done[0], 0);
        clr = 1;
        step(); clr = 0;
        #1 chk("t24 cleared", o_es[0], 0);

        // Reset in WAIT, then req0 wins the first tie
        do_reset();
        req0_src = 64'h9000; req0_dst = 64'h9100; req0_bytes = 32; req0_valid = 1;
        step(); req0_valid = 0; dreq_ready = 1;
        step(); dreq_ready = 0;
        step();
        #1 rst = 1;
        #1 chk("t25 busy", o_busy[0], 0);
        chk("t25 dma_req_valid", o_dv[0], 0);
        chk("t25 dma_req_src", o_src[0], 0);
        chk("t25 dma_req_bytes", o_bytes[0], 0);
        chk("t25 grant_id", o_gid[0], 0);
        chk("t25 req0_done", o_r0_done[0], 0);
        step();
        step(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            #1 chk("t25 no done after release", o_r0_done[0] | o_r1_done[0], 0);
        end
        req0_valid = 1; req1_valid = 1;
        #1 chk("t25 req0 wins", o_r0_rdy[0], 1);
        chk("t25 req1 waits", o_r1_rdy[0], 0);
        step(); req0_valid = 0; req1_valid = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
